fib_sweep_driver: RTL and testbench

Sequencer that sits directly upstream of the 4-bit Fibonacci-membership detector and consumes its 1-bit result. On a start request it sweeps every input code from 0 to 2^WIDTH−1 into the detector. It holds each code for a programmable settle time, then samples the detector output. It assembles a membership mask and a hit count, and reports completion with a one-cycle done pulse.

---
 rtl/fib_sweep_if.sv | 35 +++
 rtl/fib_sweep_driver.sv | 87 ++++++++
 tb/tb_fib_sweep_driver.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fib_sweep_if.sv
// Handshake bundle between the sweep sequencer and its detector/host side.
// master = sequencer, slave = detector stub / host.
interface fib_sweep_if #(
  parameter int WIDTH = 4
);
  localparam int N = 1 << WIDTH;

  logic             start;
  logic             det_out;
  logic [WIDTH-1:0] det_in;
  logic             busy;
  logic             done;
  logic [N-1:0]     mask;
  logic [WIDTH:0]   hit_count;

  modport master (
    input  start,
    input  det_out,
    output det_in,
    output busy,
    output done,
    output mask,
    output hit_count
  );

  modport slave (
    output start,
    output det_out,
    input  det_in,
    input  busy,
    input  done,
    input  mask,
    input  hit_count
  );
endinterface

// File: rtl/fib_sweep_driver.sv
// Sweeps every detector code, waits SETTLE cycles per code, then captures
// the 1-bit result into a membership mask and hit count.
module fib_sweep_driver #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input logic        clk,
  input logic        rst,
  fib_sweep_if.master sw
);
  localparam int N  = 1 << WIDTH;
  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0]    CLAST = CW'(SETTLE - 1);
  localparam logic [WIDTH-1:0] DLAST = WIDTH'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_DONE
  } st_t;

  st_t              state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] det_in;
  logic [N-1:0]     mask;
  logic [WIDTH:0]   hits;
  logic             busy;
  logic             done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      det_in <= '0;
      mask   <= '0;
      hits   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (sw.start) begin
            det_in <= '0;
            mask   <= '0;
            hits   <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          cnt <= cnt + 1'b1;
          if (cnt == CLAST)
            state <= S_SAMPLE;
        end
        S_SAMPLE: begin
          mask[det_in] <= sw.det_out;
          hits <= hits + {{WIDTH{1'b0}}, sw.det_out};
          // det_in only moves here, so each code gets SETTLE full cycles
          if (det_in == DLAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            det_in <= det_in + 1'b1;
            cnt    <= '0;
            state  <= S_DRIVE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign sw.det_in    = det_in;
  assign sw.busy      = busy;
  assign sw.done      = done;
  assign sw.mask      = mask;
  assign sw.hit_count = hits;
endmodule

// File: tb/tb_fib_sweep_driver.sv
// Directed bench: three sequencers (SETTLE 1/3/2) with selectable detector
// stubs, a vector table of full sweeps plus held-start and async-reset cases.
module tb_fib_sweep_driver;
  localparam int SET [3] = '{1, 3, 2};
  localparam int M_FIB  = 0;
  localparam int M_ONE  = 1;
  localparam int M_ZERO = 2;
  localparam int M_STAB = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  logic        start_v [3];
  int          mode_v  [3];
  logic        dout    [3];
  logic [3:0]  det_w   [3];
  logic        busy_w  [3];
  logic        done_w  [3];
  logic [15:0] mask_w  [3];
  logic [4:0]  hit_w   [3];

  logic [3:0] p1 [3];
  logic [3:0] p2 [3];
  logic       v1 [3];
  logic       v2 [3];

  fib_sweep_if #(.WIDTH(4)) if0 ();
  fib_sweep_if #(.WIDTH(4)) if1 ();
  fib_sweep_if #(.WIDTH(4)) if2 ();

  fib_sweep_driver #(.WIDTH(4), .SETTLE(1)) dut0 (
    .clk(clk), .rst(rst), .sw(if0.master));
  fib_sweep_driver #(.WIDTH(4), .SETTLE(3)) dut1 (
    .clk(clk), .rst(rst), .sw(if1.master));
  fib_sweep_driver #(.WIDTH(4), .SETTLE(2)) dut2 (
    .clk(clk), .rst(rst), .sw(if2.master));

  assign if0.start = start_v[0];
  assign if1.start = start_v[1];
  assign if2.start = start_v[2];
  assign if0.det_out = dout[0];
  assign if1.det_out = dout[1];
  assign if2.det_out = dout[2];

  assign det_w[0] = if0.det_in;
  assign det_w[1] = if1.det_in;
  assign det_w[2] = if2.det_in;
  assign busy_w[0] = if0.busy;
  assign busy_w[1] = if1.busy;
  assign busy_w[2] = if2.busy;
  assign done_w[0] = if0.done;
  assign done_w[1] = if1.done;
  assign done_w[2] = if2.done;
  assign mask_w[0] = if0.mask;
  assign mask_w[1] = if1.mask;
  assign mask_w[2] = if2.mask;
  assign hit_w[0] = if0.hit_count;
  assign hit_w[1] = if1.hit_count;
  assign hit_w[2] = if2.hit_count;

  function automatic logic is_fib(input logic [3:0] v);
    return (v == 0) || (v == 1) || (v == 2) || (v == 3) ||
           (v == 5) || (v == 8) || (v == 13);
  endfunction

  // history for the "stable for two earlier cycles" stub; idle cycles
  // never count as settled
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      p1[i] <= det_w[i];
      p2[i] <= p1[i];
      v1[i] <= busy_w[i];
      v2[i] <= v1[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      dout[i] = 1'b0;
      case (mode_v[i])
        M_FIB:  dout[i] = is_fib(det_w[i]);
        M_ONE:  dout[i] = 1'b1;
        M_ZERO: dout[i] = 1'b0;
        M_STAB: dout[i] = busy_w[i] && v1[i] && v2[i] &&
                          det_w[i] == p1[i] && p1[i] == p2[i];
        default: dout[i] = 1'b0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // entered at #1 after the edge that accepted start
  task automatic watch(input int i, input logic [15:0] em,
                       input logic [4:0] eh, input string tag);
    int s = SET[i];
    int n = 16 * (s + 1);
    int edges = 0;
    int bn = 0;
    bit walk_ok = 1'b1;
    bit got = 1'b0;
    chk({tag, "_busy_E0"}, 32'(busy_w[i]), 32'd1);
    chk({tag, "_detin_E0"}, 32'(det_w[i]), 32'd0);
    while (!got && edges < 400) begin
      if (busy_w[i]) begin
        if (det_w[i] != 4'(bn / (s + 1))) walk_ok = 1'b0;
        bn++;
      end
      @(posedge clk); #1;
      edges++;
      if (done_w[i]) got = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    // done rises on the N*(S+1)-th edge after E0 (edge N*(S+1)+1 counting E0)
    chk({tag, "_done_edge"}, edges, n);
    chk({tag, "_busy_cycles"}, bn, n);
    chk({tag, "_walk"}, 32'(walk_ok), 32'd1);
    chk({tag, "_mask"}, 32'(mask_w[i]), 32'(em));
    chk({tag, "_hits"}, 32'(hit_w[i]), 32'(eh));
    chk({tag, "_busy_in_done"}, 32'(busy_w[i]), 32'd0);
  endtask

  task automatic sweep(input int i, input logic [15:0] em,
                       input logic [4:0] eh, input string tag);
    @(negedge clk);
    start_v[i] = 1'b1;
    @(posedge clk); #1;
    start_v[i] = 1'b0;
    watch(i, em, eh, tag);
    @(posedge clk); #1;
    chk({tag, "_done_pulse_end"}, 32'(done_w[i]), 32'd0);
    chk({tag, "_mask_hold"}, 32'(mask_w[i]), 32'(em));
  endtask

  typedef struct {
    int          inst;
    int          mode;
    logic [15:0] em;
    logic [4:0]  eh;
    string       tag;
  } vec_t;

  vec_t tbl [5];

  initial begin
    bit hit7;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      mode_v[i]  = M_FIB;
    end
    tbl[0] = '{0, M_FIB,  16'h212F, 5'd7,  "fib_s1"};
    tbl[1] = '{0, M_ZERO, 16'h0000, 5'd0,  "zero_s1"};
    tbl[2] = '{1, M_ONE,  16'hFFFF, 5'd16, "one_s3"};
    tbl[3] = '{0, M_STAB, 16'h0000, 5'd0,  "stab_s1"};
    tbl[4] = '{2, M_STAB, 16'hFFFF, 5'd16, "stab_s2"};

    #12;
    chk("rst_busy", 32'(busy_w[0]), 32'd0);
    chk("rst_done", 32'(done_w[0]), 32'd0);
    chk("rst_detin", 32'(det_w[0]), 32'd0);
    chk("rst_mask", 32'(mask_w[0]), 32'd0);
    chk("rst_hits", 32'(hit_w[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_no_start", 32'(busy_w[0]), 32'd0);

    for (int k = 0; k < 5; k++) begin
      mode_v[tbl[k].inst] = tbl[k].mode;
      sweep(tbl[k].inst, tbl[k].em, tbl[k].eh, tbl[k].tag);
    end

    // start held through a whole sweep
    mode_v[0] = M_FIB;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    watch(0, 16'h212F, 5'd7, "held1");
    @(posedge clk); #1;
    chk("held_idle_busy", 32'(busy_w[0]), 32'd0);
    chk("held_idle_mask", 32'(mask_w[0]), 32'h212F);
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    chk("held_restart_mask", 32'(mask_w[0]), 32'd0);
    watch(0, 16'h212F, 5'd7, "held2");

    // asynchronous reset mid-sweep at det_in = 7
    @(posedge clk); #1;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    hit7 = 1'b0;
    for (int c = 0; c < 100 && !hit7; c++) begin
      @(posedge clk); #1;
      if (det_w[0] == 4'd7) hit7 = 1'b1;
    end
    chk("reach_detin7", 32'(hit7), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy_w[0]), 32'd0);
    chk("arst_done", 32'(done_w[0]), 32'd0);
    chk("arst_detin", 32'(det_w[0]), 32'd0);
    chk("arst_mask", 32'(mask_w[0]), 32'd0);
    chk("arst_hits", 32'(hit_w[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("arst_stays_idle", 32'(busy_w[0]), 32'd0);
    sweep(0, 16'h212F, 5'd7, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
